// File: rtl/z_to_z_deskew_collector.sv
// De-skews the systolic z_to_z accumulator stream into row-aligned vectors,
// buffers them in a circular FIFO and tags each row with its frame row index.
module z_to_z_deskew_collector #(
    parameter int data_size = 16,
    parameter int size      = 3,
    parameter int depth     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [data_size*size-1:0]      in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [data_size*size-1:0]      out_data,
    output logic                           out_last,
    output logic [$clog2(size)-1:0]        out_row,
    output logic                           overflow,
    output logic [$clog2(depth+1)-1:0]     fifo_count
);

    localparam int W     = data_size * size;
    localparam int ROW_W = $clog2(size);
    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = $clog2(depth + 1);

    // Handshake: a row transfers on any edge where out_valid && out_ready;
    // out_data/out_row/out_last hold while out_valid && !out_ready.

    logic [W-1:0] aligned_data;
    logic         aligned_valid;

    // Lane k arrives k cycles late, so it waits size-1-k stages to line up.
    for (genvar k = 0; k < size; k++) begin : g_lane
        localparam int D = size - 1 - k;
        if (D == 0) begin : g_pass
            assign aligned_data[data_size*(k+1)-1 -: data_size] =
                in_data[data_size*(k+1)-1 -: data_size];
        end else begin : g_dly
            logic [data_size-1:0] sr_q [D];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= in_data[data_size*(k+1)-1 -: data_size];
                    for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign aligned_data[data_size*(k+1)-1 -: data_size] = sr_q[D-1];
        end
    end

    if (size > 1) begin : g_vld
        logic [size-2:0] vld_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= in_valid;
                for (int i = 1; i < size - 1; i++) vld_q[i] <= vld_q[i-1];
            end
        end
        assign aligned_valid = vld_q[size-2];
    end else begin : g_vld_pass
        assign aligned_valid = in_valid;
    end

    logic [W-1:0]     mem_q [depth];
    logic [ROW_W-1:0] tag_q [depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop  = (count_q != '0) && out_ready;
    assign full = (count_q == CNT_W'(depth));
    // A full FIFO still accepts a row when a pop frees a slot on the same edge.
    assign push = aligned_valid && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d  = ptr_inc(wr_ptr_q);
            row_cnt_d = (row_cnt_q == ROW_W'(size - 1)) ? '0 : row_cnt_q + 1'b1;
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (aligned_valid && !push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the outputs are gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= aligned_data;
            tag_q[wr_ptr_q] <= row_cnt_q;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_row    = out_valid ? tag_q[rd_ptr_q] : '0;
    assign out_last   = out_valid && (out_row == ROW_W'(size - 1));
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_z_to_z_deskew_collector.sv
// Directed bench for z_to_z_deskew_collector (data_size=16, size=3, depth=4).
module tb_z_to_z_deskew_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        out_last;
    logic [1:0]  out_row;
    logic        overflow;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    z_to_z_deskew_collector #(.data_size(16), .size(3), .depth(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_row(out_row), .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rowval(input int id, input int k);
        return {8'(id), 8'(k + 1)};
    endfunction

    function automatic logic [47:0] exp_row(input int id);
        logic [47:0] r;
        for (int k = 0; k < 3; k++) r[16*k +: 16] = rowval(id, k);
        return r;
    endfunction

    // Drive cycle c of a skewed burst of n rows with ids id0..id0+n-1.
    task automatic feed(input int c, input int n, input int id0);
        in_valid = (c >= 0 && c < n);
        in_data  = '0;
        for (int k = 0; k < 3; k++) begin
            if (c - k >= 0 && c - k < n) in_data[16*k +: 16] = rowval(id0 + c - k, k);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_data"},  64'(out_data),  64'(0));
        chk({tag, "_last"},  64'(out_last),  64'(0));
        chk({tag, "_row"},   64'(out_row),   64'(0));
        chk({tag, "_ovf"},   64'(overflow),  64'(0));
        chk({tag, "_cnt"},   64'(fifo_count), 64'(0));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        #1;
        check_zero("rst");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        out_ready = 1'b0;
        apply_reset();

        // Single row: lanes arrive one per cycle, aligned output 3 cycles later.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = {16'h0, 16'h0, 16'h0100};
        chk("t1_c0_valid", 64'(out_valid), 64'(0));
        tick();
        in_valid = 1'b0; in_data = {16'h0, 16'h0200, 16'h0};
        chk("t1_c1_valid", 64'(out_valid), 64'(0));
        tick();
        in_data = {16'h0300, 16'h0, 16'h0};
        chk("t1_c2_valid", 64'(out_valid), 64'(0));
        tick();
        in_data = '0;
        chk("t1_c3_valid", 64'(out_valid), 64'(1));
        chk("t1_c3_data", 64'(out_data), 64'(48'h0300_0200_0100));
        chk("t1_c3_row", 64'(out_row), 64'(0));
        chk("t1_c3_last", 64'(out_last), 64'(0));
        chk("t1_c3_cnt", 64'(fifo_count), 64'(1));
        tick();
        chk("t1_c4_valid", 64'(out_valid), 64'(0));
        chk("t1_c4_cnt", 64'(fifo_count), 64'(0));

        // Back-to-back rows with out_last on the third.
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            feed(c, 3, 0);
            chk("t2_valid", 64'(out_valid), 64'(c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) begin
                chk("t2_data", 64'(out_data), 64'(exp_row(c - 3)));
                chk("t2_row", 64'(out_row), 64'(c - 3));
                chk("t2_last", 64'(out_last), 64'(c == 5));
            end
            tick();
        end

        // Overflow: five rows into a depth-4 FIFO with the consumer stalled.
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            feed(c, 5, 10);
            chk("t3_cnt", 64'(fifo_count), 64'((c < 3) ? 0 : ((c - 2 > 4) ? 4 : c - 2)));
            chk("t3_ovf", 64'(overflow), 64'(c >= 7));
            if (c >= 3) chk("t3_hold", 64'(out_data), 64'(exp_row(10)));
            tick();
        end
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_valid", 64'(out_valid), 64'(1));
            chk("t3_drain_data", 64'(out_data), 64'(exp_row(10 + i)));
            chk("t3_drain_row", 64'(out_row), 64'(i % 3));
            chk("t3_drain_cnt", 64'(fifo_count), 64'(4 - i));
            tick();
        end
        chk("t3_end_valid", 64'(out_valid), 64'(0));
        chk("t3_end_ovf", 64'(overflow), 64'(1));

        // Full FIFO with simultaneous push and pop.
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            out_ready = (c == 6);
            feed(c, 5, 20);
            chk("t4_cnt", 64'(fifo_count), 64'((c < 3) ? 0 : ((c - 2 > 4) ? 4 : c - 2)));
            chk("t4_ovf", 64'(overflow), 64'(0));
            if (c >= 3) chk("t4_head", 64'(out_data), 64'(exp_row((c == 7) ? 21 : 20)));
            tick();
        end
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_data", 64'(out_data), 64'(exp_row(21 + i)));
            chk("t4_drain_row", 64'(out_row), 64'((1 + i) % 3));
            chk("t4_drain_cnt", 64'(fifo_count), 64'(4 - i));
            tick();
        end
        chk("t4_end_valid", 64'(out_valid), 64'(0));
        chk("t4_end_ovf", 64'(overflow), 64'(0));

        // Stalled drain: outputs hold while out_ready is low.
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            feed(c, 3, 30);
            tick();
        end
        in_valid = 1'b0; in_data = '0;
        chk("t5_cnt", 64'(fifo_count), 64'(3));
        begin
            int idx;
            idx = 0;
            for (int j = 0; j < 5; j++) begin
                out_ready = pat[j];
                chk("t5_valid", 64'(out_valid), 64'(1));
                chk("t5_data", 64'(out_data), 64'(exp_row(30 + idx)));
                chk("t5_row", 64'(out_row), 64'(idx));
                if (pat[j]) idx++;
                tick();
            end
        end
        chk("t5_end_valid", 64'(out_valid), 64'(0));
        chk("t5_end_cnt", 64'(fifo_count), 64'(0));

        // Asynchronous reset mid-frame with one row still in the de-skew pipe.
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            feed(c, 3, 40);
            tick();
        end
        feed(4, 3, 40);
        chk("t6_pre_cnt", 64'(fifo_count), 64'(2));
        chk("t6_pre_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        in_valid = 1'b0; in_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            feed(c, 1, 50);
            chk("t6_valid", 64'(out_valid), 64'(c == 3));
            if (c == 3) begin
                chk("t6_data", 64'(out_data), 64'(exp_row(50)));
                chk("t6_row", 64'(out_row), 64'(0));
                chk("t6_last", 64'(out_last), 64'(0));
            end
            tick();
        end
        chk("t6_end_cnt", 64'(fifo_count), 64'(0));
        chk("t6_end_ovf", 64'(overflow), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/z_to_z_deskew_collector.md
Name: z_to_z_deskew_collector

Overview:
- Downstream consumer of the systolic z_to_z accumulator output.
- Takes the skewed per-lane acc_z_to_z stream (lane k arrives k cycles after lane 0), de-skews it into row-aligned vectors, and buffers rows in a small FIFO.
- Presents the rows to the weight-update stage over a valid/ready handshake, marks frame boundaries (size rows = one matrix), and flags lost rows.

Parameters:
- data_size, 16, width of one lane element (Q8.8 fixed point, passed through unmodified).
- size, 3, number of lanes per row and rows per frame.
- depth, 4, FIFO depth in rows; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  high in the cycle lane 0 of a new row is present on in_data.
- in_data  input  data_size*size  skewed row stream; lane k = bits [data_size*(k+1)-1 -: data_size].
- out_valid  output  1  out_data holds a buffered aligned row.
- out_ready  input  1  consumer accepts the row this cycle.
- out_data  output  data_size*size  aligned row, same lane layout as in_data.
- out_last  output  1  row is row size-1 of its frame.
- out_row  output  $clog2(size)  row index within frame, 0..size-1.
- overflow  output  1  sticky: at least one aligned row was dropped.
- fifo_count  output  $clog2(depth+1)  rows currently buffered.

Behaviour:
- Reset: is asynchronous and active-low. While rst_n is 0:
  - out_valid=0, out_last=0, out_row=0, overflow=0, fifo_count=0, out_data=0.
  - All de-skew registers, FIFO pointers and the frame row counter are cleared.
  - Reset mid-frame discards partial rows and buffered rows. The next in_valid after release is row 0 of a new frame.
- De-skew:
  - Lane k is delayed by (size-1-k) register stages; lane size-1 passes with zero extra delay.
  - in_valid is delayed by size-1 stages to form aligned_valid.
  - For an in_valid at cycle t, lane k is sampled at cycle t+k. The aligned row and aligned_valid are both present at cycle t+size-1.
- Overlap: in_valid may be high on consecutive cycles (back-to-back rows, one per cycle). The pipeline must not mix lanes between rows.
- Push/pop:
  - Push when aligned_valid=1.
  - Pop when out_valid && out_ready.
  - A push at the edge ending cycle t+size-1 gives out_valid=1 from cycle t+size if the FIFO was empty. Minimum latency in_valid -> out_valid is size cycles.
- Handshake rules:
  - out_data, out_last and out_row are stable while out_valid=1 && out_ready=0.
  - out_ready is ignored when out_valid=0.
- Row tagging:
  - Each pushed row carries its frame row index from a push-side counter (0..size-1, wraps to 0 after size-1).
  - out_last = (out_row == size-1).
  - The counter advances only on accepted pushes; dropped rows do not advance it.
- Full:
  - Push with fifo_count==depth and no simultaneous pop drops the row and sets overflow. overflow stays 1 until reset.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
- Empty: pop is impossible (out_valid=0). A push into an empty FIFO does not bypass to the same cycle; out_valid rises the next cycle.
- FIFO: circular buffer, read and write pointers wrap modulo depth. fifo_count is updated by +1, -1 or 0 per cycle.
- Data: no arithmetic; lanes are passed bit-exact, so sign and fraction bits are untouched.

Test Plan:
1. size=3, in_valid pulse at cycle 10 with lane0=0x0100@10, lane1=0x0200@11, lane2=0x0300@12, out_ready=1 -> out_valid only at cycle 13; out_data lanes {0x0100,0x0200,0x0300}; out_row=0, out_last=0.
2. Three back-to-back rows (in_valid cycles 10,11,12), rows r0/r1/r2 with lane values 0x0r01,0x0r02,0x0r03, out_ready=1 -> out_valid at cycles 13,14,15 carrying the correct rows; out_row 0,1,2; out_last only at cycle 15.
3. depth=4, out_ready=0, push 5 rows -> fifo_count reaches 4; 5th row dropped; overflow=1 and stays 1. Then out_ready=1 -> 4 rows out in order with out_row 0,1,2,0.
4. FIFO full, out_ready=1 during a push -> push accepted, fifo_count stays 4, overflow stays 0.
5. out_ready toggled 1-0-0-1 during a drain -> out_data/out_row held during stall cycles; no row duplicated or skipped.
6. Deassert rst_n mid-frame after 2 rows with 1 row in flight -> all outputs 0 immediately (asynchronous). After release, the next row is tagged out_row=0 and the in-flight row never appears.
